// File: rtl/debug_display.sv
`default_nettype none
// ============================================================================
//  Module      : debug_display
//  Description : Eight-digit, common-anode, active-low seven-segment driver
//                for the CPU observation bus. A debounced push-button cycles
//                through four views of the bus; the decimal point on digit 0
//                of the write-data view flags that a memory write occurred.
//  Revision    : 1.0  initial release
// ============================================================================
module debug_display #(
    parameter int N               = 32,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   pclow,
    input  logic [4:0]   state,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    input  logic         memwrite,
    input  logic [N-1:0] check,
    input  logic [N-1:0] checkm,
    input  logic         modebtn,
    output logic [7:0]   an,
    output logic [7:0]   seg,
    output logic [1:0]   mode
);

    localparam int c_PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_stable;
    logic [c_DB_W-1:0]   r_dbcnt;
    logic [1:0]          r_mode;
    logic                r_wsticky;
    logic [c_PRE_W-1:0]  r_pre;
    logic [2:0]          r_idx;
    logic [7:0]          r_an;
    logic [7:0]          r_seg;

    logic                w_accept;
    logic                w_press;
    logic [31:0]         w_adr32;
    logic [31:0]         w_word;
    logic [3:0]          w_nibble;
    logic [6:0]          w_hex;
    logic                w_dp_lit;

    // A level change is accepted once the synchronized input has differed
    // from the stable level for DEBOUNCE_CYCLES consecutive cycles.
    assign w_accept = (r_sync2 != r_stable) && (r_dbcnt == c_DB_LAST);
    assign w_press  = w_accept && r_sync2;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= modebtn;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: count cycles of disagreement, restart on any agreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_dbcnt  <= '0;
        end else if (r_sync2 == r_stable) begin
            r_dbcnt  <= '0;
        end else if (r_dbcnt == c_DB_LAST) begin
            r_stable <= r_sync2;
            r_dbcnt  <= '0;
        end else begin
            r_dbcnt  <= r_dbcnt + c_DB_W'(1);
        end
    end

    // Mode advances on an accepted press; the write flag sets on any write
    // and clears on a mode change, with a simultaneous write taking priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode    <= 2'd0;
            r_wsticky <= 1'b0;
        end else begin
            if (w_press) begin
                r_mode <= r_mode + 2'd1;
            end
            if (memwrite) begin
                r_wsticky <= 1'b1;
            end else if (w_press) begin
                r_wsticky <= 1'b0;
            end
        end
    end

    // Refresh prescaler: each digit stays lit for REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= 3'd0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // Select the 32-bit display word for the current mode (zero-extended
    // when the observed buses are narrower than 32 bits).
    always_comb begin
        w_adr32 = 32'(dataadr);
        w_word  = 32'd0;
        case (r_mode)
            2'd0:    w_word = {pclow, 3'b000, state, w_adr32[15:0]};
            2'd1:    w_word = 32'(check);
            2'd2:    w_word = 32'(checkm);
            default: w_word = 32'(writedata);
        endcase
    end

    assign w_nibble = w_word[{r_idx, 2'b00} +: 4];
    assign w_dp_lit = (r_mode == 2'd3) && (r_idx == 3'd0) && r_wsticky;

    // Hex digit to active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        w_hex = 7'h7F;
        case (w_nibble)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            default: w_hex = 7'h0E;
        endcase
    end

    // Registered digit enable and segment outputs, one cycle behind r_idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(8'b0000_0001 << r_idx);
            r_seg <= {~w_dp_lit, w_hex};
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_debug_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_display
//  Description : Self-checking bench for debug_display: directed scenarios
//                plus randomized bus/button traffic against a cycle model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debug_display;

    localparam int N = 32;
    localparam int R = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   pclow;
    logic [4:0]   state;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic         memwrite;
    logic [N-1:0] check;
    logic [N-1:0] checkm;
    logic         modebtn;
    logic [7:0]   an;
    logic [7:0]   seg;
    logic [1:0]   mode;

    always #5 clk = ~clk;

    debug_display #(.N(N), .REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .pclow(pclow), .state(state),
        .dataadr(dataadr), .writedata(writedata), .memwrite(memwrite),
        .check(check), .checkm(checkm), .modebtn(modebtn),
        .an(an), .seg(seg), .mode(mode)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] hexseg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model state
    int         k;          // clock edges since reset release
    logic [1:0] m_mode;
    logic       m_wst;
    bit         hist[$];    // button level seen at edge x is hist[x-1]
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    logic [7:0] obs [8];    // last segment value seen per digit

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_mode = 2'd0;
        m_wst = 1'b0;
        hist.delete();
        for (int d = 0; d < 8; d++) obs[d] = 8'h00;
    endtask

    // A press is taken at edge e when the button was seen high on the D
    // edges e-D-1..e-2 and low (or still in reset) on edge e-D-2.
    function automatic bit accepted(input int e);
        if (e < D + 2) return 1'b0;
        if (e - D - 2 >= 1 && hist[e-D-3]) return 1'b0;
        for (int x = e - D - 1; x <= e - 2; x++)
            if (!hist[x-1]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock with the inputs already applied, then compare.
    task automatic step();
        logic [31:0] w;
        int idx;
        bit acc;
        k++;
        hist.push_back(modebtn);
        idx = ((k - 1) / R) % 8;
        case (m_mode)
            2'd0:    w = {pclow, 3'b000, state, dataadr[15:0]};
            2'd1:    w = check;
            2'd2:    w = checkm;
            default: w = writedata;
        endcase
        exp_an  = 8'hFF ^ (8'h01 << idx);
        exp_seg = hexseg[4'(w >> (4 * idx))];
        if (m_mode == 2'd3 && idx == 0 && m_wst) exp_seg[7] = 1'b0;
        acc = accepted(k);
        if (memwrite) m_wst = 1'b1;
        else if (acc) m_wst = 1'b0;
        if (acc) m_mode = m_mode + 2'd1;
        @(posedge clk);
        @(negedge clk);
        check_eq("an", an, exp_an);
        check_eq("seg", seg, exp_seg);
        check_eq("mode", mode, m_mode);
        for (int d = 0; d < 8; d++)
            if (an == (8'hFF ^ (8'h01 << d))) obs[d] = seg;
    endtask

    task automatic press();
        modebtn = 1'b1;
        repeat (12) step();
        modebtn = 1'b0;
        repeat (14) step();
    endtask

    task automatic rand_inputs();
        pclow     = 8'($urandom);
        state     = 5'($urandom);
        dataadr   = $urandom;
        writedata = $urandom;
        check     = $urandom;
        checkm    = $urandom;
        memwrite  = ($urandom_range(15) == 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] mode0_exp [8];
        mode0_exp = '{8'h99, 8'h88, 8'hC0, 8'hC0, 8'h90, 8'hC0, 8'hC6, 8'hB0};

        reset = 1'b1;
        pclow = 8'h3C; state = 5'd9; dataadr = 32'h0000_00A4;
        writedata = 32'h0000_0010; memwrite = 1'b0;
        check = 32'hDEAD_BEEF; checkm = 32'h0; modebtn = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_an", an, 8'hFF);
        check_eq("reset_seg", seg, 8'hFF);
        check_eq("reset_mode", mode, 2'd0);
        reset = 1'b0;

        // Mode 0 scan: 3,C,0,9,0,0,A,4 on digits 7..0
        repeat (36) step();
        for (int d = 0; d < 8; d++) check_eq($sformatf("mode0_digit%0d", d), obs[d], mode0_exp[d]);

        // Short glitch ignored
        modebtn = 1'b1;
        repeat (3) step();
        modebtn = 1'b0;
        repeat (15) step();
        check_eq("glitch_mode", mode, 2'd0);

        // Long press: mode changes exactly 10 cycles after the rise
        modebtn = 1'b1;
        repeat (9) step();
        check_eq("mode_before_accept", mode, 2'd0);
        step();
        check_eq("mode_after_accept", mode, 2'd1);
        repeat (2) step();
        modebtn = 1'b0;
        repeat (14) step();

        // Mode 1: DEADBEEF, then a mid-scan change of check
        repeat (32) step();
        check_eq("mode1_digit0", obs[0], 8'h8E);
        check_eq("mode1_digit7", obs[7], 8'hA1);
        repeat (6) step();
        check = 32'h1234_5678;
        repeat (8) step();

        // Into mode 3, one-cycle write pulse lights dp on digit 0
        press();
        press();
        check_eq("mode3_reached", mode, 2'd3);
        memwrite = 1'b1;
        step();
        memwrite = 1'b0;
        for (int d = 0; d < 8; d++) obs[d] = 8'h00;
        repeat (32) step();
        check_eq("mode3_dp_digit0", obs[0], 8'h40);
        press();
        check_eq("four_presses_wrap", mode, 2'd0);
        press();
        press();
        press();
        for (int d = 0; d < 8; d++) obs[d] = 8'h00;
        repeat (32) step();
        check_eq("mode3_dp_cleared", obs[0], 8'hC0);

        // Randomized traffic and button pulses
        repeat (25) begin
            int len;
            int gap;
            len = $urandom_range(1, 20);
            gap = $urandom_range(12, 20);
            modebtn = 1'b1;
            for (int i = 0; i < len; i++) begin rand_inputs(); step(); end
            modebtn = 1'b0;
            for (int i = 0; i < gap; i++) begin rand_inputs(); step(); end
        end

        // Asynchronous reset mid-scan at digit 5 in mode 2
        memwrite = 1'b0;
        for (int i = 0; i < 8 && m_mode != 2'd2; i++) press();
        for (int i = 0; i < 64 && exp_an != 8'hDF; i++) begin rand_inputs(); memwrite = 1'b0; step(); end
        check_eq("pre_reset_mode", mode, 2'd2);
        check_eq("pre_reset_an", an, 8'hDF);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_an", an, 8'hFF);
        check_eq("async_reset_seg", seg, 8'hFF);
        check_eq("async_reset_mode", mode, 2'd0);
        @(negedge clk);
        check_eq("held_reset_an", an, 8'hFF);
        reset = 1'b0;
        model_reset();
        step();
        check_eq("restart_digit0", an, 8'hFE);
        repeat (12) begin rand_inputs(); step(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
